// File: rtl/issue_buffer.sv
// rtl/issue_buffer.sv - Out-of-order issue buffer with CDB wakeup and ALU/MULT select.
// Optional same-cycle CDB forwarding into issue is enabled by defining ISSUE_CDB_BYPASS_EN.
module issue_buffer #(
    parameter  int DEPTH   = 8,
    parameter  int N_CDB   = 2,
    parameter  int NUM_ALU = 2,
    parameter  int TAG_W   = 6,
    parameter  int DATA_W  = 32,
    parameter  int OP_W    = 4,
    localparam int PKT_W   = OP_W + TAG_W + 2 * DATA_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_class,
    input  logic [OP_W-1:0]           in_op,
    input  logic [TAG_W-1:0]          in_dest,
    input  logic [1:0]                in_src_ready,
    input  logic [2*TAG_W-1:0]        in_src_tag,
    input  logic [2*DATA_W-1:0]       in_src_val,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [N_CDB*DATA_W-1:0]   cdb_val,
    input  logic [NUM_ALU-1:0]        alu_avail,
    input  logic                      mult_avail,
    output logic [NUM_ALU-1:0]        alu_issue_valid,
    output logic [NUM_ALU*PKT_W-1:0]  alu_issue_pkt,
    output logic                      mult_issue_valid,
    output logic [PKT_W-1:0]          mult_issue_pkt,
    output logic [CNT_W-1:0]          count
);

    typedef struct packed {
        logic                        valid;
        logic                        cls;
        logic [OP_W-1:0]             op;
        logic [TAG_W-1:0]            dest;
        logic [1:0]                  rdy;
        logic [1:0][TAG_W-1:0]       tag;
        logic [1:0][DATA_W-1:0]      val;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0][1:0]              wk_hit;
    logic [DEPTH-1:0][1:0][DATA_W-1:0]  wk_val;
    logic [DEPTH-1:0][1:0]              eff_rdy;
    logic [DEPTH-1:0][1:0][DATA_W-1:0]  eff_val;
    logic [DEPTH-1:0][PKT_W-1:0]        ent_pkt;
    logic [1:0]                         in_hit;
    logic [1:0][DATA_W-1:0]             in_cval;
    logic [DEPTH-1:0]                   alu_cand, mult_cand;
    logic [NUM_ALU-1:0][DEPTH-1:0]      alu_sel;
    logic [DEPTH-1:0]                   mult_sel, issued;
    logic [CNT_W-1:0]                   issued_total;
    logic [DEPTH-1:0]                   free_oh;
    logic                               do_insert;

    // Returns {hit, value}; lanes are scanned high to low so the lowest matching lane wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [N_CDB-1:0]        vld,
        input logic [N_CDB*TAG_W-1:0]  tags,
        input logic [N_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int l = N_CDB - 1; l >= 0; l--) begin
            if (vld[l] && (tags[l*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, vals[l*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    always_comb begin : wakeup
        logic [DATA_W:0] lk;
        lk        = '0;
        wk_hit    = '0;
        wk_val    = '0;
        eff_rdy   = '0;
        eff_val   = '0;
        ent_pkt   = '0;
        in_hit    = '0;
        in_cval   = '0;
        alu_cand  = '0;
        mult_cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int o = 0; o < 2; o++) begin
                lk           = cdb_lookup(ent_q[i].tag[o], cdb_valid, cdb_tag, cdb_val);
                wk_hit[i][o] = lk[DATA_W];
                wk_val[i][o] = lk[DATA_W-1:0];
`ifdef ISSUE_CDB_BYPASS_EN
                eff_rdy[i][o] = ent_q[i].rdy[o] | wk_hit[i][o];
                eff_val[i][o] = ent_q[i].rdy[o] ? ent_q[i].val[o] : wk_val[i][o];
`else
                eff_rdy[i][o] = ent_q[i].rdy[o];
                eff_val[i][o] = ent_q[i].val[o];
`endif
            end
            ent_pkt[i]   = {ent_q[i].op, ent_q[i].dest, eff_val[i][0], eff_val[i][1]};
            alu_cand[i]  = ent_q[i].valid && (&eff_rdy[i]) && !ent_q[i].cls;
            mult_cand[i] = ent_q[i].valid && (&eff_rdy[i]) &&  ent_q[i].cls;
        end
        for (int o = 0; o < 2; o++) begin
            lk         = cdb_lookup(in_src_tag[o*TAG_W +: TAG_W], cdb_valid, cdb_tag, cdb_val);
            in_hit[o]  = lk[DATA_W];
            in_cval[o] = lk[DATA_W-1:0];
        end
    end

    // Free ALU ports take the oldest-index ready ALU entries in port order.
    always_comb begin : select
        logic [DEPTH-1:0] taken;
        logic             found;
        alu_sel      = '0;
        mult_sel     = '0;
        taken        = '0;
        found        = 1'b0;
        issued_total = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            found = 1'b0;
            if (alu_avail[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!found && alu_cand[i] && !taken[i]) begin
                        alu_sel[k][i] = 1'b1;
                        taken[i]      = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
        end
        found = 1'b0;
        if (mult_avail) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && mult_cand[i]) begin
                    mult_sel[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        issued = taken | mult_sel;
        for (int i = 0; i < DEPTH; i++) begin
            issued_total = issued_total + CNT_W'(issued[i]);
        end
    end

    always_comb begin : outputs
        alu_issue_valid  = '0;
        alu_issue_pkt    = '0;
        mult_issue_valid = |mult_sel;
        mult_issue_pkt   = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            alu_issue_valid[k] = |alu_sel[k];
            for (int i = 0; i < DEPTH; i++) begin
                alu_issue_pkt[k*PKT_W +: PKT_W] = alu_issue_pkt[k*PKT_W +: PKT_W]
                                                | (alu_sel[k][i] ? ent_pkt[i] : '0);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            mult_issue_pkt = mult_issue_pkt | (mult_sel[i] ? ent_pkt[i] : '0);
        end
    end

    // Only registered occupancy gates insertion; slots freed by issue reopen next cycle.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign count    = count_q;

    always_comb begin : next_state
        logic found;
        found     = 1'b0;
        free_oh   = '0;
        do_insert = in_valid && in_ready && !flush;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && !ent_q[i].valid) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
        count_d = flush ? '0 : (count_q + CNT_W'(do_insert) - issued_total);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (issued[i]) begin
                ent_d[i].valid = 1'b0;
            end
            for (int o = 0; o < 2; o++) begin
                if (!ent_q[i].rdy[o] && wk_hit[i][o]) begin
                    ent_d[i].rdy[o] = 1'b1;
                    ent_d[i].val[o] = wk_val[i][o];
                end
            end
            if (do_insert && free_oh[i]) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].cls   = in_class;
                ent_d[i].op    = in_op;
                ent_d[i].dest  = in_dest;
                for (int o = 0; o < 2; o++) begin
                    ent_d[i].tag[o] = in_src_tag[o*TAG_W +: TAG_W];
                    if (in_src_ready[o]) begin
                        ent_d[i].rdy[o] = 1'b1;
                        ent_d[i].val[o] = in_src_val[o*DATA_W +: DATA_W];
                    end else if (in_hit[o]) begin
                        ent_d[i].rdy[o] = 1'b1;
                        ent_d[i].val[o] = in_cval[o];
                    end else begin
                        ent_d[i].rdy[o] = 1'b0;
                        ent_d[i].val[o] = '0;
                    end
                end
            end
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// tb/tb_issue_buffer.sv - Scoreboard bench for issue_buffer select, wakeup, flush and reset.
module tb_issue_buffer;
    localparam int DEPTH   = 8;
    localparam int N_CDB   = 2;
    localparam int NUM_ALU = 2;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int PKT_W   = OP_W + TAG_W + 2 * DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                      clock, reset, flush;
    logic                      in_valid, in_ready, in_class;
    logic [OP_W-1:0]           in_op;
    logic [TAG_W-1:0]          in_dest;
    logic [1:0]                in_src_ready;
    logic [2*TAG_W-1:0]        in_src_tag;
    logic [2*DATA_W-1:0]       in_src_val;
    logic [N_CDB-1:0]          cdb_valid;
    logic [N_CDB*TAG_W-1:0]    cdb_tag;
    logic [N_CDB*DATA_W-1:0]   cdb_val;
    logic [NUM_ALU-1:0]        alu_avail;
    logic                      mult_avail;
    logic [NUM_ALU-1:0]        alu_issue_valid;
    logic [NUM_ALU*PKT_W-1:0]  alu_issue_pkt;
    logic                      mult_issue_valid;
    logic [PKT_W-1:0]          mult_issue_pkt;
    logic [CNT_W-1:0]          count;

    logic [PKT_W-1:0] exp_alu[$];
    logic [PKT_W-1:0] exp_mult[$];
    logic [PKT_W-1:0] mon_exp;
    int n_checks = 0;
    int n_pass   = 0;

    issue_buffer dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_op(in_op), .in_dest(in_dest), .in_src_ready(in_src_ready),
        .in_src_tag(in_src_tag), .in_src_val(in_src_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .alu_avail(alu_avail), .mult_avail(mult_avail),
        .alu_issue_valid(alu_issue_valid), .alu_issue_pkt(alu_issue_pkt),
        .mult_issue_valid(mult_issue_valid), .mult_issue_pkt(mult_issue_pkt),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                                                input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return {op, dest, a, b};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        flush = 0; in_valid = 0; in_class = 0; in_op = '0; in_dest = '0;
        in_src_ready = '0; in_src_tag = '0; in_src_val = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0; alu_avail = '0; mult_avail = 0;
    endtask

    task automatic drive_ins(input logic cls, input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                             input logic r0, input logic [TAG_W-1:0] t0, input logic [DATA_W-1:0] v0,
                             input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1);
        in_valid = 1; in_class = cls; in_op = op; in_dest = dest;
        in_src_ready = {r1, r0}; in_src_tag = {t1, t0}; in_src_val = {v1, v0};
    endtask

    // Scoreboard: every issued packet must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_ALU; k++) begin
                n_checks++;
                if (alu_issue_valid[k]) begin
                    if (exp_alu.size() == 0) begin
                        $display("FAIL alu_unexpected port %0d: got pkt %h, required no issue", k, alu_issue_pkt[k*PKT_W +: PKT_W]);
                    end else begin
                        mon_exp = exp_alu.pop_front();
                        if (alu_issue_pkt[k*PKT_W +: PKT_W] !== mon_exp)
                            $display("FAIL alu_pkt port %0d: got %h, required %h", k, alu_issue_pkt[k*PKT_W +: PKT_W], mon_exp);
                        else n_pass++;
                    end
                end else begin
                    if (alu_issue_pkt[k*PKT_W +: PKT_W] !== '0)
                        $display("FAIL alu_idle_pkt port %0d: got %h, required 0", k, alu_issue_pkt[k*PKT_W +: PKT_W]);
                    else n_pass++;
                end
            end
            n_checks++;
            if (mult_issue_valid) begin
                if (exp_mult.size() == 0) begin
                    $display("FAIL mult_unexpected: got pkt %h, required no issue", mult_issue_pkt);
                end else begin
                    mon_exp = exp_mult.pop_front();
                    if (mult_issue_pkt !== mon_exp)
                        $display("FAIL mult_pkt: got %h, required %h", mult_issue_pkt, mon_exp);
                    else n_pass++;
                end
            end else begin
                if (mult_issue_pkt !== '0) $display("FAIL mult_idle_pkt: got %h, required 0", mult_issue_pkt);
                else n_pass++;
            end
        end
    end

    task automatic test_reset;
        reset = 1;
        #2 reset = 0;
        #2;
        n_checks++; if (count !== 0) $display("FAIL reset_count: got %0d, required 0", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else n_pass++;
        n_checks++; if (alu_issue_valid !== '0 || alu_issue_pkt !== '0) $display("FAIL reset_alu: got %b/%h, required 0/0", alu_issue_valid, alu_issue_pkt); else n_pass++;
        n_checks++; if (mult_issue_valid !== 1'b0 || mult_issue_pkt !== '0) $display("FAIL reset_mult: got %b/%h, required 0/0", mult_issue_valid, mult_issue_pkt); else n_pass++;
        @(posedge clock); @(posedge clock); #1;
        reset = 1;
    endtask

    task automatic test_single_alu;
        drive_ins(0, 4'h3, 6'd10, 1, 6'd0, 32'h11, 1, 6'd0, 32'h22);
        exp_alu.push_back(mk_pkt(4'h3, 6'd10, 32'h11, 32'h22));
        tick; in_valid = 0; #1;
        n_checks++; if (count !== 1) $display("FAIL single_count1: got %0d, required 1", count); else n_pass++;
        n_checks++; if (alu_issue_valid !== 2'b00) $display("FAIL single_noavail: got %b, required 00", alu_issue_valid); else n_pass++;
        alu_avail = 2'b01; #1;
        n_checks++; if (alu_issue_valid !== 2'b01) $display("FAIL single_port0: got %b, required 01", alu_issue_valid); else n_pass++;
        tick; alu_avail = 2'b00;
        n_checks++; if (count !== 0) $display("FAIL single_count0: got %0d, required 0", count); else n_pass++;
        drive_ins(0, 4'h7, 6'd11, 1, 6'd0, 32'h33, 1, 6'd0, 32'h44);
        exp_alu.push_back(mk_pkt(4'h7, 6'd11, 32'h33, 32'h44));
        tick; in_valid = 0; alu_avail = 2'b10; #1;
        n_checks++; if (alu_issue_valid !== 2'b10) $display("FAIL single_port1: got %b, required 10", alu_issue_valid); else n_pass++;
        tick; alu_avail = 2'b00;
        n_checks++; if (count !== 0) $display("FAIL single_port1_count: got %0d, required 0", count); else n_pass++;
    endtask

    task automatic test_wakeup;
        logic [NUM_ALU-1:0] exp_v;
        alu_avail = 2'b01;
        drive_ins(0, 4'h5, 6'd12, 0, 6'd5, 32'h0, 1, 6'd0, 32'h7);
        exp_alu.push_back(mk_pkt(4'h5, 6'd12, 32'hDEAD, 32'h7));
        tick; in_valid = 0; #1;
        n_checks++; if (alu_issue_valid !== 2'b00) $display("FAIL wake_waiting: got %b, required 00", alu_issue_valid); else n_pass++;
        tick;
        cdb_valid = 2'b11; cdb_tag = {6'd5, 6'd5}; cdb_val = {32'hBEEF, 32'hDEAD}; #1;
`ifdef ISSUE_CDB_BYPASS_EN
        exp_v = 2'b01;
`else
        exp_v = 2'b00;
`endif
        n_checks++; if (alu_issue_valid !== exp_v) $display("FAIL wake_cdb_cycle: got %b, required %b", alu_issue_valid, exp_v); else n_pass++;
        tick; cdb_valid = '0; #1;
        exp_v = ~exp_v & 2'b01;
        n_checks++; if (alu_issue_valid !== exp_v) $display("FAIL wake_next_cycle: got %b, required %b", alu_issue_valid, exp_v); else n_pass++;
        tick; alu_avail = 2'b00; #1;
        n_checks++; if (count !== 0) $display("FAIL wake_count: got %0d, required 0", count); else n_pass++;
    endtask

    task automatic test_fill_mult;
        int guard;
        for (int i = 0; i < DEPTH; i++) begin
            drive_ins(1, 4'h9, 6'(20 + i), 0, 6'd9, 32'h0, 1, 6'd0, 32'(i));
            exp_mult.push_back(mk_pkt(4'h9, 6'(20 + i), 32'h99, 32'(i)));
            tick;
        end
        in_valid = 0; #1;
        n_checks++; if (count !== 8) $display("FAIL fill_count: got %0d, required 8", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b, required 0", in_ready); else n_pass++;
        drive_ins(1, 4'hF, 6'd63, 1, 6'd0, 32'h1, 1, 6'd0, 32'h2);
        tick; in_valid = 0; #1;
        n_checks++; if (count !== 8) $display("FAIL fill_drop_full: got %0d, required 8", count); else n_pass++;
        cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0}; cdb_val = {32'h99, 32'h0}; mult_avail = 1; #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready_issue_cycle: got %b, required 0", in_ready); else n_pass++;
`ifdef ISSUE_CDB_BYPASS_EN
        n_checks++; if (mult_issue_valid !== 1'b1) $display("FAIL fill_bypass_issue: got %b, required 1", mult_issue_valid); else n_pass++;
        tick; cdb_valid = '0; #1;
`else
        n_checks++; if (mult_issue_valid !== 1'b0) $display("FAIL fill_nobypass_hold: got %b, required 0", mult_issue_valid); else n_pass++;
        tick; cdb_valid = '0; #1;
        n_checks++; if (mult_issue_valid !== 1'b1) $display("FAIL fill_first_issue: got %b, required 1", mult_issue_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready_before_edge: got %b, required 0", in_ready); else n_pass++;
        tick; #1;
`endif
        n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_ready_after_issue: got %b, required 1", in_ready); else n_pass++;
        n_checks++; if (count !== 7) $display("FAIL fill_count7: got %0d, required 7", count); else n_pass++;
        guard = 0;
        while (count != 0 && guard < 20) begin
            tick; guard++;
        end
        n_checks++; if (count !== 0) $display("FAIL fill_drain: got %0d, required 0 within 20 cycles", count); else n_pass++;
        mult_avail = 0;
    endtask

    task automatic test_dual_alu;
        for (int i = 0; i < 3; i++) begin
            drive_ins(0, 4'h1, 6'(30 + i), 1, 6'd0, 32'(32'h100 + i), 1, 6'd0, 32'(32'h200 + i));
            exp_alu.push_back(mk_pkt(4'h1, 6'(30 + i), 32'(32'h100 + i), 32'(32'h200 + i)));
            tick;
        end
        in_valid = 0; alu_avail = 2'b11; #1;
        n_checks++; if (alu_issue_valid !== 2'b11) $display("FAIL dual_first: got %b, required 11", alu_issue_valid); else n_pass++;
        n_checks++; if (count !== 3) $display("FAIL dual_count3: got %0d, required 3", count); else n_pass++;
        tick;
        n_checks++; if (alu_issue_valid !== 2'b01) $display("FAIL dual_second: got %b, required 01", alu_issue_valid); else n_pass++;
        n_checks++; if (count !== 1) $display("FAIL dual_count1: got %0d, required 1", count); else n_pass++;
        tick;
        n_checks++; if (count !== 0 || alu_issue_valid !== 2'b00) $display("FAIL dual_done: got %0d/%b, required 0/00", count, alu_issue_valid); else n_pass++;
        alu_avail = 2'b00;
    endtask

    task automatic test_insert_capture;
        drive_ins(0, 4'hA, 6'd40, 1, 6'd0, 32'h55, 0, 6'd33, 32'h0);
        cdb_valid = 2'b10; cdb_tag = {6'd33, 6'd33}; cdb_val = {32'hCAFE, 32'hBAD0};
        exp_alu.push_back(mk_pkt(4'hA, 6'd40, 32'h55, 32'hCAFE));
        tick; in_valid = 0; cdb_valid = '0; alu_avail = 2'b01; #1;
        n_checks++; if (alu_issue_valid !== 2'b01) $display("FAIL capture_ready: got %b, required 01", alu_issue_valid); else n_pass++;
        tick; alu_avail = 2'b00;
        n_checks++; if (count !== 0) $display("FAIL capture_count: got %0d, required 0", count); else n_pass++;
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) begin
            drive_ins(0, 4'h2, 6'(50 + i), 1, 6'd0, 32'(32'h300 + i), 1, 6'd0, 32'(32'h400 + i));
            if (i == 0) exp_alu.push_back(mk_pkt(4'h2, 6'd50, 32'h300, 32'h400));
            tick;
        end
        in_valid = 0; #1;
        n_checks++; if (count !== 5) $display("FAIL flush_count5: got %0d, required 5", count); else n_pass++;
        flush = 1; alu_avail = 2'b01;
        drive_ins(0, 4'h6, 6'd60, 1, 6'd0, 32'h1, 1, 6'd0, 32'h2);
        #1;
        n_checks++; if (alu_issue_valid !== 2'b01) $display("FAIL flush_issue_kept: got %b, required 01", alu_issue_valid); else n_pass++;
        tick; flush = 0; in_valid = 0; alu_avail = 2'b11; mult_avail = 1; #1;
        n_checks++; if (count !== 0) $display("FAIL flush_count0: got %0d, required 0", count); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (alu_issue_valid !== 2'b00 || mult_issue_valid !== 1'b0)
                $display("FAIL flush_no_issue cycle %0d: got %b/%b, required 00/0", c, alu_issue_valid, mult_issue_valid);
            else n_pass++;
            tick;
        end
        alu_avail = 2'b00; mult_avail = 0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            drive_ins(i[0], 4'h4, 6'(1 + i), 1, 6'd0, 32'(i), 1, 6'd0, 32'(i));
            tick;
        end
        drive_ins(0, 4'h4, 6'd9, 1, 6'd0, 32'h9, 1, 6'd0, 32'h9);
        #2 reset = 0; alu_avail = 2'b11; mult_avail = 1; #1;
        n_checks++; if (count !== 0) $display("FAIL rstmid_count: got %0d, required 0", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); else n_pass++;
        n_checks++; if (alu_issue_valid !== 2'b00 || mult_issue_valid !== 1'b0) $display("FAIL rstmid_issue: got %b/%b, required 00/0", alu_issue_valid, mult_issue_valid); else n_pass++;
        tick; reset = 1; in_valid = 0; #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (count !== 0 || alu_issue_valid !== 2'b00 || mult_issue_valid !== 1'b0)
                $display("FAIL rstmid_after cycle %0d: got %0d/%b/%b, required 0/00/0", c, count, alu_issue_valid, mult_issue_valid);
            else n_pass++;
            tick;
        end
        alu_avail = 2'b00; mult_avail = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        tick;
        test_single_alu();
        test_wakeup();
        test_fill_mult();
        test_dual_alu();
        test_insert_capture();
        test_flush();
        test_reset_mid();
        tick;
        n_checks++; if (exp_alu.size() != 0) $display("FAIL alu_outstanding: got %0d, required 0", exp_alu.size()); else n_pass++;
        n_checks++; if (exp_mult.size() != 0) $display("FAIL mult_outstanding: got %0d, required 0", exp_mult.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
